// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch-stage signals: the ROM port, the PC/redirect inputs and the
// decode-side handshake.
//
// Handshake (decode side): a head entry transfers on a rising clock edge where
// inst_valid && inst_ready are both high. inst_valid never depends on
// inst_ready. The entry fields inst/inst_pc/inst_fault are meaningful only
// while inst_valid is high.
//
// Modports:
//   master : the fetch unit (drives rom_addr, inst_*, dbg_state)
//   slave  : the environment (ROM, PC/redirect logic, decode)
//
// Signals:
//   rom_addr       ROM word address (ROM_AW bits)
//   rom_data       asynchronous ROM read data (32)
//   fetch_en       fetch permitted
//   redirect_valid branch/jump/trap redirect strobe
//   redirect_pc    redirect target (32)
//   inst_valid     FIFO head valid
//   inst_ready     decode accepts head
//   inst, inst_pc  head instruction and its PC (32 each)
//   inst_fault     head is a fetch fault
//   dbg_state      current FSM state (0=FETCH, 1=HALT, 2=FAULT)
// -----------------------------------------------------------------------------
interface if_fetch_unit_if #(
    parameter int ROM_AW = 11
);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              fetch_en;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              inst_fault;
    logic [1:0]        dbg_state;

    modport master (
        output rom_addr,
        input  rom_data,
        input  fetch_en,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output inst_fault,
        output dbg_state
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output fetch_en,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  inst_fault,
        input  dbg_state
    );
endinterface

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: holds the PC, addresses the asynchronous instruction
// ROM and buffers {pc, inst, fault} entries in a small FIFO that feeds decode.
// A redirect flushes the FIFO and reloads the PC. A misaligned or out-of-range
// PC produces a single fault entry carrying a NOP, after which fetching stops
// until the next redirect.
//
// Ports:
//   clk            core clock, all state on the rising edge
//   rstn           asynchronous active-low reset
//   bus            if_fetch_unit_if.master (ROM, redirect and decode signals)
//   perf_fetch_cnt pushes performed (only with IF_PERF_EN)
//   perf_stall_cnt cycles blocked by a full FIFO (only with IF_PERF_EN)
//
// Optional feature macro: IF_PERF_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ROM_AW     = 11,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    if_fetch_unit_if.master  bus
`ifdef IF_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [PW:0]   r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_mem_inst  [FIFO_DEPTH];
    logic [31:0]   r_mem_pc    [FIFO_DEPTH];
    logic          r_mem_fault [FIFO_DEPTH];

    logic          w_fault;
    logic          w_push;
    logic          w_pop;
    logic          w_full;

    // Fault when the PC is not word aligned or lies beyond the ROM.
    assign w_fault = (r_pc[1:0] != 2'b00) || (|r_pc[31:ROM_AW+2]);
    // Full uses the registered count: a same-cycle pop does not free a slot.
    assign w_full  = (r_count == DEPTH_C);
    assign w_push  = (r_state == S_FETCH) && bus.fetch_en && !w_full && !bus.redirect_valid;
    assign w_pop   = (r_count != '0) && bus.inst_ready && !bus.redirect_valid;

    assign bus.rom_addr   = r_pc[ROM_AW+1:2];
    assign bus.inst_valid = (r_count != '0);
    assign bus.inst       = r_mem_inst[r_rptr];
    assign bus.inst_pc    = r_mem_pc[r_rptr];
    assign bus.inst_fault = r_mem_fault[r_rptr];
    assign bus.dbg_state  = r_state;

    // Next-state logic; redirect overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            w_state_nxt = bus.fetch_en ? S_FETCH : S_HALT;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!bus.fetch_en)          w_state_nxt = S_HALT;
                    else if (w_push && w_fault) w_state_nxt = S_FAULT;
                end
                S_HALT:  if (bus.fetch_en) w_state_nxt = S_FETCH;
                S_FAULT: w_state_nxt = S_FAULT;
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    // PC, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push && !w_fault) r_pc <= r_pc + 32'd4;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
        end
    end

    // Entry storage; a fault entry carries a NOP instead of ROM data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_inst[i]  <= '0;
                r_mem_pc[i]    <= '0;
                r_mem_fault[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_inst[r_wptr]  <= w_fault ? NOP : bus.rom_data;
            r_mem_pc[r_wptr]    <= r_pc;
            r_mem_fault[r_wptr] <= w_fault;
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((r_state == S_FETCH) && bus.fetch_en && w_full && !bus.redirect_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage for the scpu core. Sits directly upstream of the instruction ROM (11-bit word address, 32-bit asynchronous read data) and downstream of the PC/redirect logic. Holds the PC, drives the ROM address, and buffers fetched {pc, inst, fault} entries in a small FIFO. The FIFO feeds decode through a valid/ready handshake and is flushed on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
ROM_AW, 11, ROM word-address width; reachable range is 0 .. 4*2^ROM_AW-1 bytes
FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2

Ports:
clk  input  1  core clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
rom_addr  output  ROM_AW  ROM word address = pc[ROM_AW+1:2], combinational from the PC register
rom_data  input  32  ROM read data, valid in the same cycle as rom_addr
fetch_en  input  1  fetch permitted; low = halt fetching (FIFO still drains)
redirect_valid  input  1  branch/jump/trap redirect
redirect_pc  input  32  redirect target
inst_valid  output  1  FIFO head valid (count != 0)
inst_ready  input  1  decode accepts head
inst  output  32  head instruction
inst_pc  output  32  head PC
inst_fault  output  1  head is a fetch fault (misaligned or out-of-range PC)

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC; FIFO count=0, pointers=0, storage=0; state=FETCH; inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
- States:
  - FETCH: normal operation.
  - HALT: entered when fetch_en=0; returns to FETCH when fetch_en=1.
  - FAULT: entered after a fault entry is pushed; left only on redirect or reset.
- Push condition, evaluated each cycle: state==FETCH && fetch_en && count<FIFO_DEPTH (registered count; a same-cycle pop does not free a slot) && !redirect_valid.
- Normal push: entry {pc, rom_data, fault=0}; pc<=pc+4, 32-bit wrap.
- Fault push: taken when pc[1:0]!=0 or pc[31:ROM_AW+2]!=0. Entry {pc, 32'h0000_0013 (NOP), fault=1}; pc unchanged; next state FAULT. No further pushes until redirect.
- Pop: inst_valid && inst_ready. Head advances; pop and push in the same cycle keeps count unchanged.
- Redirect, which dominates everything else in the cycle:
  - FIFO flushed (count=0, pointers reset); any same-cycle pop and push are discarded.
  - pc<=redirect_pc; state<=FETCH if fetch_en, else HALT.
  - inst_valid=0 in the next cycle; the first new entry is pushed that cycle and is valid the cycle after.
- Latency: PC-to-inst_valid is 1 cycle. First instruction after reset release is valid in cycle 1. With inst_ready held high, throughput is 1 instruction/cycle and steady-state count is 1.
- Outputs inst/inst_pc/inst_fault are driven directly from FIFO head storage. Their value is don't-care while inst_valid=0 (bench checks only when valid).
- fetch_en falling mid-stream: the entry pushed in the last enabled cycle is kept; no pushes while low; the FIFO keeps draining.
- FIFO full with inst_ready=0: pc holds; rom_addr stable; no overwrite.
- Reset asserted mid-operation: immediate return to the reset values above; buffered entries are lost.

Optional Feature:
IF_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on every push (normal or fault).
  - perf_stall_cnt increments on each cycle with state==FETCH, fetch_en=1, count==FIFO_DEPTH and no redirect.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, ROM[0..3]=A0..A3, inst_ready=1 -> inst_valid rises cycle 1; inst sequence A0,A1,A2,A3 with inst_pc 0,4,8,C, one per cycle.
- inst_ready=0 for 5 cycles after reset -> count saturates at 2 (entries pc 0,4); rom_addr holds 2; releasing ready gives pc 0,4,8 with no gaps or duplicates.
- Redirect to 32'h100 while FIFO holds pc 8,C and inst_ready=1 -> next cycle inst_valid=0; following cycle inst_pc=0x100, inst=ROM[0x40]; entries for 8 and C never delivered.
- Redirect to 32'h102 -> one entry inst_pc=0x102, inst=0x00000013, inst_fault=1, then no further valid entries. Redirect to 0x10 resumes with inst_pc 0x10, fault=0.
- PC reaches 0x1FFC (ROM_AW=11) -> entry 0x1FFC normal; next entry inst_pc=0x2000, inst_fault=1; fetching stops.
- Async rstn pulse mid-stream with FIFO holding 2 entries -> inst_valid=0 immediately. With IF_PERF_EN, both counters read 0; after 4 free-running fetches perf_fetch_cnt=4.
